// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter for a 32-bit word, least-significant byte first.
// Optional self-triggering on data_in change: define UART_AUTO_SEND_EN.
module uart_word_tx #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD      = 115200,
    parameter int NUM_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        start,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BYTE_MAX = 3'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [31:0]   shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          go;
    logic          tick;
    logic [31:0]   word_cap;

`ifdef UART_AUTO_SEND_EN
    logic [31:0]   data_q;
    logic [31:0]   last_q, last_d;

    // Auto-send compares the registered input against the last word sent.
    assign go       = start | (data_q != last_q);
    assign word_cap = start ? data_in : data_q;

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && go) begin
            last_d = word_cap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 32'd0;
            last_q <= 32'd0;
        end else begin
            data_q <= data_in;
            last_q <= last_d;
        end
    end
`else
    assign go       = start;
    assign word_cap = data_in;
`endif

    assign tick = (baud_q == BAUD_MAX);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    shift_d = word_cap;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    baud_d = '0;
                    byte_d = byte_q + 3'd1;
                    // Next byte follows directly with no idle gap.
                    if (byte_q == BYTE_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DONE: begin
                byte_d  = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so tx never glitches.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            shift_q <= 32'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
